// File: rtl/vga_scan_timing.sv
// rtl/vga_scan_timing.sv - VGA raster timing generator with latency-aligned DAC output stage
//
// Free-running hcount/vcount raster, raw sync/blank decode, a PIX_LAT-deep
// delay line that keeps sync/blank in step with the blobs' pixel path, and
// a registered DAC output stage.
//
// Ports:
//   pixel_clk    in   pixel clock, all state on the rising edge
//   reset        in   asynchronous, active-high
//   clk_en       in   advance enable; all state holds while low
//   pixel[23:0]  in   {R,G,B} from the blobs, PIX_LAT enabled cycles behind hcount/vcount
//   hcount[10:0] out  horizontal position 0..H_TOTAL-1
//   vcount[9:0]  out  line number 0..V_TOTAL-1
//   frame_start  out  one enabled-cycle pulse while the counters read (0,0) after a frame wrap
//   vga_r/g/b    out  8-bit colour to the DAC, forced to 0 during blanking
//   vga_hs/vs    out  sync at SYNC_POL active level
//   vga_blank_n  out  low during blanking

module vga_scan_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIX_LAT  = 1
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [23:0] pixel,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        frame_start,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_pix_lat
        $error("vga_scan_timing: PIX_LAT must be within 0..7");
    end
    if (H_TOTAL > 2048) begin : g_bad_h_total
        $error("vga_scan_timing: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_scan_timing: V_TOTAL exceeds 1024");
    end

    // Decode thresholds are one bit wider than the counters so a sync
    // region ending exactly at H_TOTAL/V_TOTAL (zero back porch) cannot
    // wrap to zero.
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEGIN   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEGIN   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line word: {blank, hsync active, vsync active}. Reset value is
    // blanked with both syncs inactive.
    localparam logic [2:0] TIM_IDLE = 3'b100;

    logic [11:0] hc_w;
    logic [10:0] vc_w;
    logic        at_h_last;
    logic        at_v_last;
    logic        wrap_pend;
    logic [2:0]  tim_raw;
    logic [2:0]  tim_d;

    assign hc_w      = {1'b0, hcount};
    assign vc_w      = {1'b0, vcount};
    assign at_h_last = (hc_w == H_LAST);
    assign at_v_last = (vc_w == V_LAST);

    // ---------------- raster counters ----------------
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hcount    <= '0;
            vcount    <= '0;
            wrap_pend <= 1'b0;
        end else if (clk_en) begin
            // Only a genuine frame wrap arms the pulse, so the (0,0)
            // after reset never produces frame_start.
            wrap_pend <= at_h_last && at_v_last;
            if (at_h_last) begin
                hcount <= '0;
                vcount <= at_v_last ? '0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 11'd1;
            end
        end
    end

    // Gating with clk_en keeps the pulse to exactly one enabled cycle even
    // when the enable drops right after the wrap.
    assign frame_start = wrap_pend & clk_en;

    // ---------------- raw timing decode ----------------
    always_comb begin
        tim_raw    = TIM_IDLE;
        tim_raw[2] = (hc_w >= H_ACT_END) || (vc_w >= V_ACT_END);
        tim_raw[1] = (hc_w >= HS_BEGIN) && (hc_w < HS_END);
        tim_raw[0] = (vc_w >= VS_BEGIN) && (vc_w < VS_END);
    end

    // ---------------- alignment delay line ----------------
    if (PIX_LAT == 0) begin : g_no_delay
        assign tim_d = tim_raw;
    end else begin : g_delay
        logic [2:0] stage [PIX_LAT];

        always_ff @(posedge pixel_clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIX_LAT; i++) begin
                    stage[i] <= TIM_IDLE;
                end
            end else if (clk_en) begin
                stage[0] <= tim_raw;
                for (int i = 1; i < PIX_LAT; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign tim_d = stage[PIX_LAT-1];
    end

    // ---------------- DAC output stage ----------------
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            vga_blank_n <= 1'b0;
        end else if (clk_en) begin
            vga_hs      <= tim_d[1] ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= tim_d[0] ? SYNC_POL : ~SYNC_POL;
            vga_blank_n <= ~tim_d[2];
            // Blob pixels are discarded outright during blanking so the
            // DAC always sees black outside the active window.
            if (tim_d[2]) begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end else begin
                vga_r <= pixel[23:16];
                vga_g <= pixel[15:8];
                vga_b <= pixel[7:0];
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb/tb_vga_scan_timing.sv - scoreboard bench for vga_scan_timing at PIX_LAT 1, 0 and 3

module tb_vga_scan_timing;

    localparam int NI = 3;
    localparam int HA [NI] = '{640, 16, 16};
    localparam int HF [NI] = '{16, 2, 2};
    localparam int HS [NI] = '{96, 3, 3};
    localparam int HB [NI] = '{48, 3, 3};
    localparam int VA [NI] = '{480, 6, 6};
    localparam int VF [NI] = '{10, 1, 1};
    localparam int VS [NI] = '{2, 2, 2};
    localparam int VB [NI] = '{33, 2, 2};
    localparam int LAT [NI] = '{1, 0, 3};

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        fs;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bn;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] pix [NI];
    logic [10:0] hc [NI];
    logic [9:0]  vc [NI];
    logic        fs [NI];
    logic [7:0]  r [NI];
    logic [7:0]  g [NI];
    logic [7:0]  b [NI];
    logic        hsy [NI];
    logic        vsy [NI];
    logic        bln [NI];
    obs_t        act [NI];

    obs_t exp_q [NI][$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   k       = 0;
    logic cur_rst = 1'b1;
    logic cur_en  = 1'b1;

    always #5 clk = ~clk;

    vga_scan_timing dut0 (
        .pixel_clk(clk), .reset(rst), .clk_en(en), .pixel(pix[0]),
        .hcount(hc[0]), .vcount(vc[0]), .frame_start(fs[0]),
        .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]),
        .vga_hs(hsy[0]), .vga_vs(vsy[0]), .vga_blank_n(bln[0])
    );

    vga_scan_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .PIX_LAT(0)
    ) dut1 (
        .pixel_clk(clk), .reset(rst), .clk_en(en), .pixel(pix[1]),
        .hcount(hc[1]), .vcount(vc[1]), .frame_start(fs[1]),
        .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]),
        .vga_hs(hsy[1]), .vga_vs(vsy[1]), .vga_blank_n(bln[1])
    );

    vga_scan_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .PIX_LAT(3)
    ) dut2 (
        .pixel_clk(clk), .reset(rst), .clk_en(en), .pixel(pix[2]),
        .hcount(hc[2]), .vcount(vc[2]), .frame_start(fs[2]),
        .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]),
        .vga_hs(hsy[2]), .vga_vs(vsy[2]), .vga_blank_n(bln[2])
    );

    for (genvar gi = 0; gi < NI; gi++) begin : g_act
        assign act[gi] = {hc[gi], vc[gi], fs[gi], r[gi], g[gi], b[gi], hsy[gi], vsy[gi], bln[gi]};
    end

    // Screen coordinate visited after n enabled edges since reset.
    function automatic int h_of(int i, int n);
        return n % (HA[i] + HF[i] + HS[i] + HB[i]);
    endfunction

    function automatic int v_of(int i, int n);
        return (n / (HA[i] + HF[i] + HS[i] + HB[i])) % (VA[i] + VF[i] + VS[i] + VB[i]);
    endfunction

    function automatic logic blank_of(int i, int n);
        return (h_of(i, n) >= HA[i]) || (v_of(i, n) >= VA[i]);
    endfunction

    // Blob model: real pixel data for visible positions, junk while blanked.
    function automatic logic [23:0] blob_pixel(int i, int n);
        int j;
        j = n - LAT[i];
        if (j >= 0 && !blank_of(i, j))
            return {8'(h_of(i, j)), 8'(v_of(i, j)), 8'hA5};
        return 24'($urandom);
    endfunction

    // Expected DAC/counter view after n enabled edges; outputs describe
    // the position LAT+1 enabled edges earlier.
    function automatic obs_t model(int i, int n, logic en_now);
        obs_t o;
        int   j, h, v, frame;
        frame = (HA[i] + HF[i] + HS[i] + HB[i]) * (VA[i] + VF[i] + VS[i] + VB[i]);
        o.h  = 11'(h_of(i, n));
        o.v  = 10'(v_of(i, n));
        o.fs = (n > 0) && (n % frame == 0) && en_now;
        if (n < LAT[i] + 1) begin
            o.rgb = '0; o.hs = 1'b1; o.vs = 1'b1; o.bn = 1'b0;
        end else begin
            j = n - LAT[i] - 1;
            h = h_of(i, j);
            v = v_of(i, j);
            o.hs  = !(h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]);
            o.vs  = !(v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]);
            o.bn  = !blank_of(i, j);
            o.rgb = blank_of(i, j) ? 24'h0 : {8'(h), 8'(v), 8'hA5};
        end
        return o;
    endfunction

    // One clock: account for the edge just taken, then drive the next
    // cycle's inputs and push what the DUTs must show during it.
    task automatic step(input logic new_rst, input logic new_en);
        @(posedge clk);
        #2;
        if (cur_rst) k = 0;
        else if (cur_en) k = k + 1;
        cur_rst = new_rst;
        cur_en  = new_en;
        rst     = new_rst;
        en      = new_en;
        if (new_rst) k = 0;
        for (int i = 0; i < NI; i++) begin
            pix[i] = blob_pixel(i, k);
            exp_q[i].push_back(model(i, k, new_en && !new_rst));
        end
    endtask

    task automatic check_int(input string name, input int actual, input int required);
        n_tests++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                    n_tests++;
                    if (act[i] !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard dut%0d t=%0t actual h=%0d v=%0d fs=%b rgb=%h hs=%b vs=%b bn=%b required h=%0d v=%0d fs=%b rgb=%h hs=%b vs=%b bn=%b",
                                 i, $time, act[i].h, act[i].v, act[i].fs, act[i].rgb, act[i].hs, act[i].vs, act[i].bn,
                                 e.h, e.v, e.fs, e.rgb, e.hs, e.vs, e.bn);
                    end
                end
            end
        end
    end

    initial begin : driver
        int hs_low, bn_high, fs_cnt, v_max;
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < NI; i++) pix[i] = '0;

        repeat (5) step(1'b1, 1'b1);

        hs_low = 0; bn_high = 0; fs_cnt = 0; v_max = 0;
        for (int n = 0; n < 2000; n++) begin
            step(1'b0, 1'b1);
            if (n >= 1000 && n < 1800) begin
                if (hsy[0] == 1'b0) hs_low++;
                if (bln[0] == 1'b1) bn_high++;
            end
            if (n >= 1000 && n < 1264) begin
                if (fs[1]) fs_cnt++;
                if (int'(vc[1]) > v_max) v_max = int'(vc[1]);
            end
        end
        check_int("hsync_low_per_line", hs_low, 96);
        check_int("blank_n_high_per_line", bn_high, 640);
        check_int("frame_start_per_frame", fs_cnt, 1);
        check_int("vcount_max", v_max, 10);

        for (int n = 0; n < 1700; n++) step(1'b0, (n % 2) == 0);
        for (int n = 0; n < 3000; n++) step(1'b0, $urandom_range(0, 3) != 0);

        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int n = 0; n < 3000; n++) step(1'b0, $urandom_range(0, 3) != 0);
        repeat (4) step(1'b0, 1'b1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
